// File: rtl/seq1001_pkg.sv
// Shared types for the time-shared "1001" detector: per-channel context encoding
// and the pattern being searched for.
package seq1001_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,  // idle
    S1 = 2'd1,  // seen "1"
    S2 = 2'd2,  // seen "10"
    S3 = 2'd3   // seen "100"
  } st_t;

  localparam logic [3:0] PAT = 4'b1001;

endpackage

// File: rtl/seq1001_step.sv
// One step of the overlapping "1001" detector: (context, bit) -> (next context, match).
// Purely combinational so a single copy can serve every channel.
module seq1001_step
  import seq1001_pkg::*;
(
  input  st_t  st,
  input  logic b,
  output st_t  nst,
  output logic match
);

  always_comb begin
    nst   = S0;
    match = 1'b0;
    case (st)
      S0: nst = b ? S1 : S0;
      S1: nst = b ? S1 : S2;
      S2: nst = b ? S1 : S3;
      // The completing 1 also starts the next pattern, hence S1 rather than S0.
      S3: begin
        nst   = b ? S1 : S0;
        match = (b == PAT[0]);
      end
      default: nst = S0;
    endcase
  end

endmodule

// File: rtl/seq1001_sched.sv
// Round-robin scheduler sharing one "1001" detector across NCH serial streams.
// Each channel keeps a 2-bit context; only the granted channel advances per cycle.
module seq1001_sched
  import seq1001_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           req,
  input  logic [NCH-1:0]           bit_in,
  input  logic [NCH-1:0]           clr,
  output logic [NCH-1:0]           gnt,
  output logic                     hit,
  output logic [$clog2(NCH)-1:0]   hit_ch,
  output logic [NCH*CW-1:0]        match_cnt
);

  localparam int IW = $clog2(NCH);

  st_t                      ctx [NCH];
  logic [NCH-1:0][CW-1:0]   cnt;
  logic [IW-1:0]            last;
  logic [NCH-1:0]           elig;
  logic [IW-1:0]            gidx;
  logic                     any;
  st_t                      nst;
  logic                     match;

  // A clear wins over a request: the bit stays pending until clr drops.
  assign elig = req & ~clr;

  always_comb begin
    int idx;
    idx  = 0;
    any  = 1'b0;
    gidx = '0;
    gnt  = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(last) + k) % NCH;
      if (!any && elig[idx]) begin
        any  = 1'b1;
        gidx = idx[IW-1:0];
      end
    end
    if (any && rst_n) gnt[gidx] = 1'b1;
  end

  seq1001_step u_step (
    .st    (ctx[gidx]),
    .b     (bit_in[gidx]),
    .nst   (nst),
    .match (match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) ctx[i] <= S0;
      cnt    <= '0;
      last   <= IW'(NCH - 1);
      hit    <= 1'b0;
      hit_ch <= '0;
    end else begin
      hit <= any & match;
      if (any) begin
        ctx[gidx] <= nst;
        last      <= gidx;
        if (match) begin
          hit_ch <= gidx;
          if (cnt[gidx] != '1) cnt[gidx] <= cnt[gidx] + CW'(1);
        end
      end
      // A cleared channel is never the granted one, so these never collide.
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          ctx[i] <= S0;
          cnt[i] <= '0;
        end
      end
    end
  end

  assign match_cnt = cnt;

endmodule

// File: tb/tb_seq1001_sched.sv
// Directed bench for seq1001_sched: one default instance plus a CW=2 instance
// for counter saturation.
module tb_seq1001_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0, bit_in = '0, clr = '0;
  logic [3:0]  gnt;
  logic        hit;
  logic [1:0]  hit_ch;
  logic [31:0] match_cnt;

  logic [3:0]  sreq = '0, sbit = '0, sclr = '0;
  logic [3:0]  sgnt;
  logic        shit;
  logic [1:0]  shit_ch;
  logic [7:0]  scnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq1001_sched #(.NCH(4), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .bit_in(bit_in), .clr(clr),
    .gnt(gnt), .hit(hit), .hit_ch(hit_ch), .match_cnt(match_cnt)
  );

  seq1001_sched #(.NCH(4), .CW(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .req(sreq), .bit_in(sbit), .clr(sclr),
    .gnt(sgnt), .hit(shit), .hit_ch(shit_ch), .match_cnt(scnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] b, input logic [3:0] c);
    req = r; bit_in = b; clr = c;
    #1;
  endtask

  // Feed one bit to channel c alone and check grant, then hit after the edge.
  task automatic feed(input int c, input logic b, input logic exp_hit, input string tag);
    logic [3:0] m;
    m = 4'(1 << c);
    drive(m, b ? m : 4'h0, 4'h0);
    chk({tag, "_gnt"}, 32'(gnt), 32'(m));
    tick();
    chk({tag, "_hit"}, 32'(hit), 32'(exp_hit));
    if (exp_hit) chk({tag, "_hitch"}, 32'(hit_ch), 32'(c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] pat;
    int         m;
    pat = 4'b1001;

    // Reset state; requests present but gnt must stay low.
    req = 4'hF; bit_in = 4'hF;
    #12;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_hit", 32'(hit), 32'h0);
    chk("rst_hitch", 32'(hit_ch), 32'h0);
    chk("rst_cnt", match_cnt, 32'h0);
    drive(4'h0, 4'h0, 4'h0);
    tick();
    rst_n = 1'b1;
    #1;

    // Channel 0: 1,0,0,1 -> single hit on the 4th bit.
    feed(0, 1'b1, 1'b0, "c0_b0");
    feed(0, 1'b0, 1'b0, "c0_b1");
    feed(0, 1'b0, 1'b0, "c0_b2");
    feed(0, 1'b1, 1'b1, "c0_b3");
    chk("c0_cnt", 32'(match_cnt[7:0]), 32'd1);
    drive(4'h0, 4'h0, 4'h0);
    chk("idle_gnt", 32'(gnt), 32'h0);
    tick();
    chk("idle_hit", 32'(hit), 32'h0);

    // Channel 1: 1001001 -> overlapping, two hits.
    feed(1, 1'b1, 1'b0, "c1_0");
    feed(1, 1'b0, 1'b0, "c1_1");
    feed(1, 1'b0, 1'b0, "c1_2");
    feed(1, 1'b1, 1'b1, "c1_3");
    feed(1, 1'b0, 1'b0, "c1_4");
    feed(1, 1'b0, 1'b0, "c1_5");
    feed(1, 1'b1, 1'b1, "c1_6");
    chk("c1_cnt", 32'(match_cnt[15:8]), 32'd2);
    chk("c0_cnt_kept", 32'(match_cnt[7:0]), 32'd1);

    // All four requesting after reset: rotation 0,1,2,3 with interleaved patterns.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      drive(4'hF, pat[3 - c/4] ? 4'hF : 4'h0, 4'h0);
      chk("rr_gnt", 32'(gnt), 32'(1 << (c % 4)));
      tick();
      chk("rr_hit", 32'(hit), 32'(c >= 12));
      if (c >= 12) chk("rr_hitch", 32'(hit_ch), 32'(c - 12));
    end
    drive(4'hF, 4'h0, 4'h0);
    chk("rr_wrap_gnt", 32'(gnt), 32'h1);
    drive(4'h0, 4'h0, 4'h0);
    chk("rr_cnts", match_cnt, 32'h01010101);

    // Channel 2 driven to S3, then clr together with a pending 1.
    feed(2, 1'b0, 1'b0, "cl_0");
    feed(2, 1'b0, 1'b0, "cl_1");
    drive(4'h4, 4'h4, 4'h4);
    chk("cl_gnt", 32'(gnt), 32'h0);
    tick();
    chk("cl_hit", 32'(hit), 32'h0);
    chk("cl_cnt", 32'(match_cnt[23:16]), 32'h0);
    chk("cl_other", 32'(match_cnt[31:24]), 32'h1);
    feed(2, 1'b1, 1'b0, "cl_regrant");
    feed(2, 1'b0, 1'b0, "cl_s2");
    feed(2, 1'b0, 1'b0, "cl_s3");
    feed(2, 1'b1, 1'b1, "cl_match");
    chk("cl_cnt2", 32'(match_cnt[23:16]), 32'h1);

    // Saturation on the CW=2 instance: leading 1 then six "001" groups.
    m = 0;
    for (int k = 0; k < 19; k++) begin
      sreq = 4'h1;
      sbit = {3'b000, (k == 0) || (k % 3 == 0)};
      #1;
      chk("sat_gnt", 32'(sgnt), 32'h1);
      tick();
      if (k > 0 && k % 3 == 0) m++;
      chk("sat_hit", 32'(shit), 32'(k > 0 && k % 3 == 0));
      chk("sat_cnt", 32'(scnt[1:0]), 32'(m > 3 ? 3 : m));
    end
    sreq = 4'h0;
    chk("sat_hits", 32'(m), 32'd6);

    // Channel 3 to S3, channel 2 completes a match, then reset mid-cycle.
    feed(3, 1'b0, 1'b0, "mr_0");
    feed(3, 1'b0, 1'b0, "mr_1");
    feed(2, 1'b0, 1'b0, "mr_2");
    feed(2, 1'b0, 1'b0, "mr_3");
    feed(2, 1'b1, 1'b1, "mr_4");
    drive(4'h8, 4'h8, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_hit", 32'(hit), 32'h0);
    chk("mr_hitch", 32'(hit_ch), 32'h0);
    chk("mr_cnt", match_cnt, 32'h0);
    chk("mr_gnt", 32'(gnt), 32'h0);
    tick();
    rst_n = 1'b1;
    drive(4'hF, 4'hF, 4'h0);
    chk("mr_first", 32'(gnt), 32'h1);
    drive(4'h8, 4'h8, 4'h0);
    chk("mr_gnt3", 32'(gnt), 32'h8);
    tick();
    chk("mr_nohit", 32'(hit), 32'h0);
    chk("mr_cnt3", 32'(match_cnt[31:24]), 32'h0);
    drive(4'h0, 4'h0, 4'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq1001_sched.md
# seq1001_sched

Round-robin scheduler that time-shares one "1001" pattern-detect engine among `NCH` serial bit streams. Each channel's detector state is stored as a 2-bit context and is advanced only when that channel is granted. Per-channel saturating match counters and a match pulse are reported to downstream status logic. The block sits between the serial front-ends and the status/interrupt block.

## Interface
- `NCH`, default 4: number of requesting channels, 2..16.
- `CW`, default 8: match counter width per channel.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req` input NCH: channel i has a bit pending; held with `bit_in[i]` until granted.
- `bit_in` input NCH: serial bit of channel i; valid while `req[i]`=1.
- `clr` input NCH: synchronous per-channel clear of context and counter.
- `gnt` output NCH: one-hot or zero, combinational; `bit_in[i]` is consumed on the edge where `gnt[i]`=1.
- `hit` output 1: registered one-cycle pulse; a pattern completed.
- `hit_ch` output $clog2(NCH): channel of the current `hit`.
- `match_cnt` output NCH*CW: packed counters; channel i at bits [i*CW +: CW].

## Operation
- Context states per channel:
  - S0: idle.
  - S1: seen "1".
  - S2: seen "10".
  - S3: seen "100".
- Transitions with input b, overlapping detection:
  - S0: b=1 → S1, b=0 → S0.
  - S1: b=1 → S1, b=0 → S2.
  - S2: b=1 → S1, b=0 → S3.
  - S3: b=1 → S1 with match, b=0 → S0.
- Match fires on the S3 + b=1 step. The trailing 1 is reused as the leading 1 of the next pattern: "1001001" yields 2 matches.
- Arbitration:
  - Eligible set is `req & ~clr`.
  - Round-robin pointer `last` holds the last granted channel.
  - Search starts at `last+1` mod NCH.
  - The first eligible channel is granted; `last` updates to it on the edge.
  - At most one grant per cycle.
- On a granted edge:
  - ctx[g] ← next state.
  - On a match: match_cnt[g] increments, saturating at 2^CW−1; hit ← 1; hit_ch ← g.
  - Otherwise hit ← 0.
- `clr[i]` on an edge:
  - ctx[i] ← S0 and match_cnt[i] ← 0.
  - Channel i is not granted that cycle; its pending bit stays pending.
  - Takes priority over any other event on channel i.
- Ungranted channels keep their context unchanged.

## Timing
- Reset values:
  - ctx all S0; `last` = NCH−1, so channel 0 has first priority.
  - `hit` = 0, `hit_ch` = 0, `match_cnt` all 0.
  - `gnt` = 0 while `rst_n` is low.
- Grant latency: `gnt` follows `req` combinationally in the same cycle.
- Match latency: `hit` rises the cycle after the edge that consumed the completing bit, and lasts exactly 1 cycle unless the next grant also matches. The counter updates on the same edge as `hit`.
- Throughput: one bit per cycle total. Under full load each channel is granted once every NCH cycles.
- Counter saturation: at 2^CW−1 the counter holds, and `hit` still pulses.
- Reset mid-stream: all contexts are lost immediately and asynchronously. Partial patterns do not survive reset.
- No requests: `gnt` = 0, no state change, `hit` = 0 next cycle.

## Structure
- Package `seq1001_pkg` holds:
  - the 2-bit state type with constants S0..S3;
  - the pattern constant 4'b1001.
- Sub-module `seq1001_step`: purely combinational (state, bit) → (next state, match). It is instantiated once and muxed by grant index.
- Top-level registers: ctx array, `last` pointer, counters, `hit`/`hit_ch`.

## Test plan
- Single channel 0, req held high, bits 1,0,0,1 → gnt[0] each cycle; hit=1, hit_ch=0 the cycle after 4th bit; match_cnt[0]=1.
- Channel 1 streams 1,0,0,1,0,0,1 → two hit pulses; match_cnt[1]=2.
- All 4 requesting after reset → grants 0,1,2,3,0 in consecutive cycles. Each channel fed 1,0,0,1 interleaved → 4 hits with hit_ch 0,1,2,3; no cross-channel corruption.
- Channel 2 at S3, `clr[2]` and `req[2]` both high with bit 1 → no gnt[2], no hit, ctx S0, count 0. Next cycle the same bit is granted → ctx S1.
- CW=2, channel 0 fed six patterns → count saturates at 3, six hit pulses.
- `rst_n` low mid-pattern (channel 3 at S3) → all outputs reset immediately. After release, bit 1 alone gives no hit; grant order restarts at channel 0.
